// File: rtl/srec_parser_if.sv
// Character-in / byte-write-out bundle of the S-record loader.
// The character source drives the master side; the parser sits on the slave side.
interface srec_parser_if;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        error;
    logic [7:0]  error_location;
    logic [31:0] write_address;
    logic [7:0]  write_byte;
    logic        write_enable;

    modport master (
        output char_data,
        output char_ready,
        input  error,
        input  error_location,
        input  write_address,
        input  write_byte,
        input  write_enable
    );

    modport slave (
        input  char_data,
        input  char_ready,
        output error,
        output error_location,
        output write_address,
        output write_byte,
        output write_enable
    );
endinterface

// File: rtl/srec_parser.sv
// Motorola S-record parser: turns an ASCII character stream into byte writes,
// checking record length and checksum and latching the first error code.
module srec_parser (
    input  logic         clock,
    input  logic         reset_n,
    srec_parser_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, TYPE, COUNT, ADDR, DATA, CKSUM, EOL, ERROR
    } state_t;

    state_t      state, state_next;
    logic        half, half_next;
    logic [3:0]  high_nibble, high_nibble_next;
    logic [3:0]  rec_type, rec_type_next;
    logic [2:0]  addr_len, addr_len_next;
    logic [2:0]  addr_left, addr_left_next;
    logic [7:0]  data_left, data_left_next;
    logic [7:0]  sum, sum_next;
    logic [31:0] address, address_next;
    logic        error_q, error_next;
    logic [7:0]  error_code, error_code_next;
    logic [31:0] wr_address, wr_address_next;
    logic [7:0]  wr_byte, wr_byte_next;
    logic        wr_enable, wr_enable_next;

    logic        is_hex;
    logic [3:0]  hex_value;
    logic        is_eol;
    logic [7:0]  byte_value;
    logic [7:0]  sum_with_byte;
    logic [7:0]  raise_code;

    // Character classification; the low nibble of '0'..'9' is the digit, A-F/a-f add 9.
    always_comb begin
        is_hex    = 1'b1;
        hex_value = 4'd0;
        if (bus.char_data >= 8'h30 && bus.char_data <= 8'h39)
            hex_value = bus.char_data[3:0];
        else if ((bus.char_data >= 8'h41 && bus.char_data <= 8'h46) ||
                 (bus.char_data >= 8'h61 && bus.char_data <= 8'h66))
            hex_value = bus.char_data[3:0] + 4'd9;
        else
            is_hex = 1'b0;
    end

    assign is_eol        = (bus.char_data == 8'h0D) || (bus.char_data == 8'h0A);
    assign byte_value    = {high_nibble, hex_value};
    assign sum_with_byte = sum + byte_value;

    always_comb begin
        state_next       = state;
        half_next        = half;
        high_nibble_next = high_nibble;
        rec_type_next    = rec_type;
        addr_len_next    = addr_len;
        addr_left_next   = addr_left;
        data_left_next   = data_left;
        sum_next         = sum;
        address_next     = address;
        error_next       = error_q;
        error_code_next  = error_code;
        wr_address_next  = wr_address;
        wr_byte_next     = wr_byte;
        wr_enable_next   = 1'b0;
        raise_code       = 8'd0;

        if (bus.char_ready) begin
            case (state)
                IDLE: begin
                    if (bus.char_data == 8'h53)
                        state_next = TYPE;
                    else if (!is_eol)
                        raise_code = 8'd1;
                end
                TYPE: begin
                    if (bus.char_data >= 8'h30 && bus.char_data <= 8'h39 &&
                        bus.char_data != 8'h34) begin
                        rec_type_next = bus.char_data[3:0];
                        case (bus.char_data[3:0])
                            4'd2, 4'd6, 4'd8: addr_len_next = 3'd3;
                            4'd3, 4'd7:       addr_len_next = 3'd4;
                            default:          addr_len_next = 3'd2;
                        endcase
                        sum_next     = 8'd0;
                        half_next    = 1'b0;
                        address_next = 32'd0;
                        state_next   = COUNT;
                    end else begin
                        raise_code = 8'd2;
                    end
                end
                COUNT, ADDR, DATA, CKSUM: begin
                    if (!is_hex) begin
                        raise_code = 8'd3;
                    end else if (!half) begin
                        high_nibble_next = hex_value;
                        half_next        = 1'b1;
                    end else begin
                        half_next = 1'b0;
                        sum_next  = sum_with_byte;
                        case (state)
                            COUNT: begin
                                if (byte_value < {5'd0, addr_len} + 8'd1) begin
                                    raise_code = 8'd4;
                                end else begin
                                    data_left_next = byte_value - 8'd1 - {5'd0, addr_len};
                                    addr_left_next = addr_len;
                                    state_next     = ADDR;
                                end
                            end
                            ADDR: begin
                                address_next   = {address[23:0], byte_value};
                                addr_left_next = addr_left - 3'd1;
                                if (addr_left == 3'd1)
                                    state_next = (data_left == 8'd0) ? CKSUM : DATA;
                            end
                            DATA: begin
                                // Only S1/S2/S3 carry memory data; other types just consume bytes.
                                if (rec_type == 4'd1 || rec_type == 4'd2 || rec_type == 4'd3) begin
                                    wr_enable_next  = 1'b1;
                                    wr_address_next = address;
                                    wr_byte_next    = byte_value;
                                end
                                address_next   = address + 32'd1;
                                data_left_next = data_left - 8'd1;
                                if (data_left == 8'd1)
                                    state_next = CKSUM;
                            end
                            CKSUM: begin
                                if (sum_with_byte != 8'hFF)
                                    raise_code = 8'd5;
                                else
                                    state_next = EOL;
                            end
                            default: ;
                        endcase
                    end
                end
                EOL: begin
                    if (is_eol)
                        state_next = IDLE;
                    else
                        raise_code = 8'd6;
                end
                default: ;
            endcase
        end

        if (raise_code != 8'd0) begin
            state_next      = ERROR;
            error_next      = 1'b1;
            error_code_next = raise_code;
            wr_enable_next  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            half        <= 1'b0;
            high_nibble <= 4'd0;
            rec_type    <= 4'd0;
            addr_len    <= 3'd0;
            addr_left   <= 3'd0;
            data_left   <= 8'd0;
            sum         <= 8'd0;
            address     <= 32'd0;
            error_q     <= 1'b0;
            error_code  <= 8'd0;
            wr_address  <= 32'd0;
            wr_byte     <= 8'd0;
            wr_enable   <= 1'b0;
        end else begin
            state       <= state_next;
            half        <= half_next;
            high_nibble <= high_nibble_next;
            rec_type    <= rec_type_next;
            addr_len    <= addr_len_next;
            addr_left   <= addr_left_next;
            data_left   <= data_left_next;
            sum         <= sum_next;
            address     <= address_next;
            error_q     <= error_next;
            error_code  <= error_code_next;
            wr_address  <= wr_address_next;
            wr_byte     <= wr_byte_next;
            wr_enable   <= wr_enable_next;
        end
    end

    assign bus.error          = error_q;
    assign bus.error_location = error_code;
    assign bus.write_address  = wr_address;
    assign bus.write_byte     = wr_byte;
    assign bus.write_enable   = wr_enable;
endmodule

// File: tb/tb_srec_parser.sv
// Directed and randomized S-record streams checked against a string-level
// reference parser that predicts the write list and the final error code.
module tb_srec_parser;
    logic clock;
    logic reset_n;
    srec_parser_if bus();

    srec_parser dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          total_checks = 0;
    int          passed_checks = 0;
    string       hist = "";
    logic [31:0] obs_addr[$];
    logic [7:0]  obs_data[$];
    logic [31:0] exp_addr[$];
    logic [7:0]  exp_data[$];
    int          exp_code;

    always @(negedge clock) begin
        if (bus.write_enable === 1'b1) begin
            obs_addr.push_back(bus.write_address);
            obs_data.push_back(bus.write_byte);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int hexv(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        return -1;
    endfunction

    // 0 = byte read, 1 = stream ended mid-byte, 2 = non-hex character
    function automatic int get_byte(input string s, inout int i, output int b);
        int hi, lo;
        b = 0;
        if (i >= s.len()) return 1;
        hi = hexv(s[i]);
        if (hi < 0) return 2;
        if (i + 1 >= s.len()) return 1;
        lo = hexv(s[i+1]);
        if (lo < 0) return 2;
        b = hi * 16 + lo;
        i += 2;
        return 0;
    endfunction

    // Reference parse of everything sent since the last reset.
    function automatic void run_model(input string s);
        int i, n, t, alen, cnt, b, st, sum;
        logic [31:0] a;
        logic [7:0] c;
        exp_addr.delete();
        exp_data.delete();
        exp_code = 0;
        i = 0;
        n = s.len();
        while (i < n) begin
            c = s[i];
            if (c == 8'h0D || c == 8'h0A) begin i++; continue; end
            if (c != "S") begin exp_code = 1; return; end
            i++;
            if (i >= n) return;
            c = s[i];
            if (c < "0" || c > "9" || c == "4") begin exp_code = 2; return; end
            t = int'(c) - 48;
            alen = (t == 0 || t == 1 || t == 5 || t == 9) ? 2 :
                   ((t == 2 || t == 6 || t == 8) ? 3 : 4);
            i++;
            st = get_byte(s, i, cnt);
            if (st == 1) return;
            if (st == 2) begin exp_code = 3; return; end
            if (cnt < alen + 1) begin exp_code = 4; return; end
            sum = cnt;
            a = 0;
            for (int k = 0; k < alen; k++) begin
                st = get_byte(s, i, b);
                if (st == 1) return;
                if (st == 2) begin exp_code = 3; return; end
                a = a * 256 + 32'(b);
                sum += b;
            end
            for (int k = 0; k < cnt - 1 - alen; k++) begin
                st = get_byte(s, i, b);
                if (st == 1) return;
                if (st == 2) begin exp_code = 3; return; end
                sum += b;
                if (t >= 1 && t <= 3) begin
                    exp_addr.push_back(a + 32'(k));
                    exp_data.push_back(8'(b));
                end
            end
            st = get_byte(s, i, b);
            if (st == 1) return;
            if (st == 2) begin exp_code = 3; return; end
            if (((sum + b) % 256) != 255) begin exp_code = 5; return; end
            if (i >= n) return;
            c = s[i];
            if (c != 8'h0D && c != 8'h0A) begin exp_code = 6; return; end
            i++;
        end
    endfunction

    function automatic string hex2(input logic [7:0] b, input bit lower);
        if (lower) return $sformatf("%02x", b);
        return $sformatf("%02X", b);
    endfunction

    function automatic string make_record(input int t, input logic [31:0] a,
                                          input int nd, input bit lower);
        int alen;
        logic [7:0] sum, b;
        string r;
        alen = (t == 0 || t == 1 || t == 5 || t == 9) ? 2 :
               ((t == 2 || t == 6 || t == 8) ? 3 : 4);
        r = $sformatf("S%0d", t);
        b = 8'(alen + nd + 1);
        r = {r, hex2(b, lower)};
        sum = b;
        for (int k = alen - 1; k >= 0; k--) begin
            b = a[8*k +: 8];
            r = {r, hex2(b, lower)};
            sum = sum + b;
        end
        for (int k = 0; k < nd; k++) begin
            b = 8'($urandom);
            r = {r, hex2(b, lower)};
            sum = sum + b;
        end
        b = ~sum;
        r = {r, hex2(b, lower), "\r\n"};
        return r;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        total_checks++;
        assert (observed === expected) passed_checks++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic send_char(input logic [7:0] c, input int gap);
        bus.char_data  = c;
        bus.char_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.char_ready = 1'b0;
        repeat (gap) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic apply_stimulus(input string s, input int gap_max);
        hist = {hist, s};
        for (int i = 0; i < s.len(); i++)
            send_char(s[i], int'($urandom_range(0, gap_max)));
    endtask

    task automatic verify_segment(input string tag);
        int n;
        repeat (2) @(posedge clock);
        @(negedge clock);
        run_model(hist);
        check_output({tag, "_nwrites"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
        n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        for (int k = 0; k < n; k++) begin
            check_output($sformatf("%s_addr%0d", tag, k), 64'(obs_addr[k]), 64'(exp_addr[k]));
            check_output($sformatf("%s_data%0d", tag, k), 64'(obs_data[k]), 64'(exp_data[k]));
        end
        check_output({tag, "_error"}, 64'(bus.error), 64'(exp_code != 0));
        check_output({tag, "_location"}, 64'(bus.error_location), 64'(exp_code));
        check_output({tag, "_we_idle"}, 64'(bus.write_enable), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        bus.char_ready = 1'b0;
        reset_n = 1'b0;
        #3;
        check_output({tag, "_rst_error"}, 64'(bus.error), 64'd0);
        check_output({tag, "_rst_location"}, 64'(bus.error_location), 64'd0);
        check_output({tag, "_rst_we"}, 64'(bus.write_enable), 64'd0);
        check_output({tag, "_rst_addr"}, 64'(bus.write_address), 64'd0);
        check_output({tag, "_rst_byte"}, 64'(bus.write_byte), 64'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        obs_addr.delete();
        obs_data.delete();
        hist = "";
        #1;
    endtask

    initial begin
        int t, nd;
        logic [31:0] a;
        int types[6] = '{0, 1, 2, 3, 5, 9};
        reset_n        = 1'b0;
        bus.char_data  = 8'h00;
        bus.char_ready = 1'b0;
        #12;
        do_reset("init");

        apply_stimulus("S1071000AABBCCB7\r\n", 2);
        verify_segment("s1_basic");
        apply_stimulus("S306123456785A8B\n", 0);
        verify_segment("s3_basic");
        apply_stimulus("S9030000FC\r\n", 0);
        verify_segment("s9_term");
        apply_stimulus("\r\n\n\r", 0);
        apply_stimulus("S1071000AABBCCB7\r\n", 0);
        verify_segment("s1_b2b");
        apply_stimulus(make_record(3, 32'hFFFF_FFFE, 4, 1'b1), 1);
        verify_segment("s3_wrap");

        for (int r = 0; r < 14; r++) begin
            t  = types[$urandom_range(0, 5)];
            a  = $urandom;
            nd = int'($urandom_range(0, 5));
            if ($urandom_range(0, 2) == 0) apply_stimulus("\r\n", 0);
            apply_stimulus(make_record(t, a, nd, 1'($urandom)), (r % 2 == 0) ? 0 : 2);
            verify_segment($sformatf("rand%0d", r));
        end

        do_reset("ck");
        apply_stimulus("S1071000AABBCCB8\r\n", 1);
        verify_segment("bad_cksum");
        apply_stimulus("S1071000AABBCCB7\r\n", 0);
        verify_segment("after_err");

        do_reset("e1");
        apply_stimulus("X", 0);
        verify_segment("bad_start");
        do_reset("e2");
        apply_stimulus("S4030000FC\r\n", 0);
        verify_segment("bad_type");
        do_reset("e3");
        apply_stimulus("S1G", 0);
        verify_segment("bad_hex");
        do_reset("e4");
        apply_stimulus("S1020000FD\r\n", 0);
        verify_segment("bad_count");
        do_reset("e6");
        apply_stimulus("S1071000AABBCCB7Z", 0);
        verify_segment("bad_eol");

        do_reset("mid");
        apply_stimulus("S1071000AAB", 0);
        verify_segment("partial");
        do_reset("abort");
        apply_stimulus("S1071000AABBCCB7\r\n", 0);
        verify_segment("after_abort");

        $display("[TB] %0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end
endmodule
